// File: rtl/snn_img_host_if.sv
// snn_img_host_if: image ROM, UART tx/rx and result signals of the SNN image host
interface snn_img_host_if #(parameter int ADDR_W = 10);
  logic start;
  logic [ADDR_W-1:0] img_addr;
  logic img_bit;
  logic [7:0] tx_data;
  logic trmt;
  logic tx_done;
  logic rx_rdy;
  logic [7:0] rx_data;
  logic busy;
  logic result_vld;
  logic [3:0] result_digit;
  logic result_err;
  modport master (
    input start, img_bit, tx_done, rx_rdy, rx_data,
    output img_addr, tx_data, trmt, busy, result_vld, result_digit, result_err
  );
  modport slave (
    output start, img_bit, tx_done, rx_rdy, rx_data,
    input img_addr, tx_data, trmt, busy, result_vld, result_digit, result_err
  );
endinterface

// File: rtl/snn_img_host.sv
// snn_img_host: streams a 1-bit ROM image as packed UART bytes, then waits for a digit reply.
// Optional response watchdog: define SNN_HOST_TIMEOUT_EN.
module snn_img_host #(
  parameter int IMG_BITS = 784,
  parameter int ADDR_W = 10,
  parameter int TIMEOUT_CYC = 5000000
) (
  input logic clk,
  input logic rst_n,
  snn_img_host_if.master bus
);
  localparam int NBYTES = IMG_BITS / 8;
  localparam int CW = $clog2(NBYTES);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_TX, RESP} state_t;
  state_t state;
  logic [CW-1:0] byte_cnt;
  logic [3:0] f;
  logic [6:0] sh;
  if (IMG_BITS % 8 != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("snn_img_host: IMG_BITS must be a multiple of 8 and TIMEOUT_CYC >= 1");
  end
`ifdef SNN_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      byte_cnt <= '0;
      f <= '0;
      sh <= '0;
      bus.img_addr <= '0;
      bus.tx_data <= '0;
      bus.trmt <= 1'b0;
      bus.busy <= 1'b0;
      bus.result_vld <= 1'b0;
      bus.result_digit <= '0;
      bus.result_err <= 1'b0;
`ifdef SNN_HOST_TIMEOUT_EN
      tcnt <= '0;
`endif
    end else begin
      bus.trmt <= 1'b0;
      bus.result_vld <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= FETCH;
          bus.busy <= 1'b1;
          byte_cnt <= '0;
          f <= '0;
          bus.img_addr <= '0;
          bus.result_digit <= '0;
          bus.result_err <= 1'b0;
        end
        FETCH: begin
          // address leads the captured bit by one cycle; cycle 8 captures the last bit
          f <= f + 4'd1;
          if (f >= 4'd1 && f <= 4'd7) sh[f[2:0] - 3'd1] <= bus.img_bit;
          if (f < 4'd7) bus.img_addr <= bus.img_addr + ADDR_W'(1);
          if (f == 4'd8) begin
            bus.tx_data <= {bus.img_bit, sh};
            bus.trmt <= 1'b1;
            state <= SEND;
          end
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: if (bus.tx_done) begin
          if (byte_cnt == CW'(NBYTES - 1)) begin
            state <= RESP;
`ifdef SNN_HOST_TIMEOUT_EN
            tcnt <= '0;
`endif
          end else begin
            byte_cnt <= byte_cnt + CW'(1);
            f <= '0;
            bus.img_addr <= bus.img_addr + ADDR_W'(1);
            state <= FETCH;
          end
        end
        RESP: begin
          if (bus.rx_rdy) begin
            bus.result_digit <= bus.rx_data[3:0];
            bus.result_err <= bus.rx_data > 8'h09;
            bus.result_vld <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end
`ifdef SNN_HOST_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            bus.result_digit <= 4'hF;
            bus.result_err <= 1'b1;
            bus.result_vld <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end else tcnt <= tcnt + TW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/snn_img_host.md
Name: snn_img_host

Overview:
- Host-side counterpart of the SNN UART loader: streams one 784-pixel binary image from a 1-bit-wide image ROM to the SNN board as 98 UART bytes.
- Then waits for the one-byte digit result returned by the board.
- Drives an existing uart_tx instance and listens on an existing uart_rx instance.
- Used on the host/test FPGA and as the stimulus master in system-level benches.

Parameters:
- IMG_BITS, 784, pixels per image; must be a multiple of 8.
- ADDR_W, 10, width of the image ROM address.
- TIMEOUT_CYC, 5000000, response watchdog limit in clk cycles (100 ms at 50 MHz). Used only with SNN_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- img_addr  out  ADDR_W  image ROM read address
- img_bit  in  1  ROM data; valid the cycle after img_addr is presented
- tx_data  out  8  byte to uart_tx
- trmt  out  1  one-cycle pulse; uart_tx loads tx_data
- tx_done  in  1  one-cycle pulse from uart_tx when a byte has fully shifted out
- rx_rdy  in  1  one-cycle pulse from uart_rx; rx_data valid
- rx_data  in  8  received byte
- busy  out  1  high from accepted start until return to IDLE
- result_vld  out  1  one-cycle pulse when a result is latched
- result_digit  out  4  digit from last response; held until next accepted start
- result_err  out  1  set with result_vld if the response byte > 0x09 (or on timeout); held like result_digit

Behaviour:
- Clock and reset:
  - All flops on posedge clk.
  - When rst_n is sampled low: state=IDLE, all counters 0.
  - Output reset values: img_addr=0, tx_data=0, trmt=0, busy=0, result_vld=0, result_digit=0, result_err=0.
  - Reset mid-transfer aborts with no further trmt; the partial image is discarded.
- Packing: byte k (0..97) holds pixels 8k..8k+7, with pixel 8k+i in bit i. UART is LSB-first, so pixels appear on the wire in address order.
- States:
  - IDLE: start=1 -> FETCH; clears result_digit/result_err; byte_cnt=0. start while busy is ignored.
  - FETCH: drives img_addr=8*byte_cnt+j for j=0..7 on consecutive cycles. Captures img_bit one cycle later into shift bit j. Takes exactly 9 cycles, then -> SEND.
  - SEND: tx_data=assembled byte, trmt=1 for exactly one cycle -> WAIT_TX. tx_data is held stable until the next SEND.
  - WAIT_TX: waits for tx_done. On tx_done: if byte_cnt=IMG_BITS/8-1 -> RESP, else byte_cnt+1 -> FETCH. tx_done is ignored in any other state.
  - RESP: on rx_rdy, latch result_digit=rx_data[3:0] and result_err=(rx_data>8'h09). Pulse result_vld -> IDLE.
- rx_rdy outside RESP is ignored, including a stray byte during the image send.
- busy=1 in every state except IDLE. It drops in the same cycle result_vld is high.
- Per-byte overhead: 9 FETCH + 1 SEND cycles plus the UART frame time.
- img_addr does not wrap: the maximum address is IMG_BITS-1 = 783.

Optional Feature:
- Macro SNN_HOST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RESP and increments each cycle in RESP.
  - When it reaches TIMEOUT_CYC-1 with no rx_rdy: result_vld pulses, result_err=1, result_digit=4'hF, -> IDLE.
  - rx_rdy in the same cycle as the terminal count wins (normal result).
- Not defined: RESP waits indefinitely; no counter logic is synthesized.

Test Plan:
- ROM pattern pixel n = n[0] (alternating), start pulse -> 98 trmt pulses, every tx_data=8'hAA. img_addr sequence covers 0..783 exactly once, in order.
- ROM all zeros except pixel 783=1 -> bytes 0..96 = 8'h00 and byte 97 = 8'h80. Then reply rx_data=8'h07 -> result_vld pulse, result_digit=7, result_err=0, busy low the same cycle.
- Reply rx_data=8'h3A -> result_vld, result_digit=4'hA, result_err=1.
- start re-pulsed during byte 40 plus stray rx_rdy=1 with 8'h05 during WAIT_TX -> no restart, count continues to 98, no result_vld until RESP.
- rst_n low for 1 cycle in WAIT_TX of byte 12 -> all outputs at reset values the next cycle. A following start sends byte 0 again from img_addr=0.
- With SNN_HOST_TIMEOUT_EN and TIMEOUT_CYC=100: no reply -> result_vld exactly 100 cycles after RESP entry, with result_err=1 and result_digit=4'hF.
